// File: rtl/call_stack_controller.sv
`default_nettype none
// ============================================================================
//  Module      : call_stack_controller
//  Description : Circular hardware return-address stack for JSB/RTS. The top
//                entry is presented combinationally for the PC mux. Overflow
//                silently overwrites the oldest entry. Overflow and underflow
//                each set a sticky flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module call_stack_controller #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic                       stack_clr,
    input  logic                       err_clr,
    output logic [ADDR_W-1:0]          top_addr,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow_err,
    output logic                       underflow_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] c_depth   = CW'(DEPTH);
    localparam logic [CW-1:0] c_cnt_one = CW'(1);
    localparam logic [PW-1:0] c_ptr_one = PW'(1);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wp_q;
    logic [PW-1:0]     w_wp_d;
    logic [CW-1:0]     r_count_q;
    logic [CW-1:0]     w_count_d;
    logic              r_ovf_q;
    logic              w_ovf_d;
    logic              r_unf_q;
    logic              w_unf_d;

    logic              w_mem_we;
    logic [PW-1:0]     w_mem_waddr;
    logic [PW-1:0]     w_top_idx;
    logic              w_empty;
    logic              w_full;
    logic              w_ovf_evt;
    logic              w_unf_evt;

    // The pointer width is exactly log2(DEPTH), so wrap-around is free.
    assign w_top_idx = r_wp_q - c_ptr_one;
    assign w_empty   = (r_count_q == '0);
    assign w_full    = (r_count_q == c_depth);

    // Next-state decode. stack_clr beats push/pop, and the error flags are
    // kept independent of it.
    always_comb begin
        w_wp_d      = r_wp_q;
        w_count_d   = r_count_q;
        w_mem_we    = 1'b0;
        w_mem_waddr = r_wp_q;
        w_ovf_evt   = 1'b0;
        w_unf_evt   = 1'b0;
        if (stack_clr) begin
            w_wp_d    = '0;
            w_count_d = '0;
        end else if (push && pop) begin
            if (!w_empty) begin
                // A call in the same cycle as a return replaces the top entry.
                w_mem_we    = 1'b1;
                w_mem_waddr = w_top_idx;
            end else begin
                // The pop is evaluated first and underflows. The push then lands on an empty stack.
                w_unf_evt = 1'b1;
                w_mem_we  = 1'b1;
                w_wp_d    = r_wp_q + c_ptr_one;
                w_count_d = c_cnt_one;
            end
        end else if (push) begin
            w_mem_we = 1'b1;
            w_wp_d   = r_wp_q + c_ptr_one;
            if (w_full) begin
                w_ovf_evt = 1'b1;
            end else begin
                w_count_d = r_count_q + c_cnt_one;
            end
        end else if (pop) begin
            if (w_empty) begin
                w_unf_evt = 1'b1;
            end else begin
                w_wp_d    = r_wp_q - c_ptr_one;
                w_count_d = r_count_q - c_cnt_one;
            end
        end
        // If err_clr and a new error event occur in the same cycle, the new event sets the flag.
        w_ovf_d = (r_ovf_q & ~err_clr) | w_ovf_evt;
        w_unf_d = (r_unf_q & ~err_clr) | w_unf_evt;
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wp_q    <= '0;
            r_count_q <= '0;
            r_ovf_q   <= 1'b0;
            r_unf_q   <= 1'b0;
        end else begin
            r_wp_q    <= w_wp_d;
            r_count_q <= w_count_d;
            r_ovf_q   <= w_ovf_d;
            r_unf_q   <= w_unf_d;
        end
    end

    // Entry storage is not reset. Writes are suppressed while rst is asserted.
    always_ff @(posedge clk) begin
        if (w_mem_we && !rst) begin
            r_mem[w_mem_waddr] <= push_addr;
        end
    end

    assign top_addr      = w_empty ? '0 : r_mem[w_top_idx];
    assign count         = r_count_q;
    assign empty         = w_empty;
    assign full          = w_full;
    assign overflow_err  = r_ovf_q;
    assign underflow_err = r_unf_q;

endmodule
`default_nettype wire

// File: tb/tb_call_stack_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_call_stack_controller
//  Description : Directed bench for call_stack_controller (DEPTH=8, ADDR_W=12)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_call_stack_controller;

    localparam int DEPTH  = 8;
    localparam int ADDR_W = 12;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic              stack_clr;
    logic              err_clr;
    logic [ADDR_W-1:0] top_addr;
    logic [CW-1:0]     count;
    logic              empty;
    logic              full;
    logic              overflow_err;
    logic              underflow_err;

    int n_checks;
    int n_pass;

    call_stack_controller #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .push         (push),
        .pop          (pop),
        .push_addr    (push_addr),
        .stack_clr    (stack_clr),
        .err_clr      (err_clr),
        .top_addr     (top_addr),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow_err (overflow_err),
        .underflow_err(underflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of stimulus. Sampling happens 1ns after the edge.
    task automatic step(input logic i_push, input logic i_pop, input logic [ADDR_W-1:0] i_addr,
                        input logic i_clr, input logic i_eclr);
        push      = i_push;
        pop       = i_pop;
        push_addr = i_addr;
        stack_clr = i_clr;
        err_clr   = i_eclr;
        @(posedge clk);
        #1;
        push      = 1'b0;
        pop       = 1'b0;
        push_addr = '0;
        stack_clr = 1'b0;
        err_clr   = 1'b0;
    endtask

    task automatic check_state(input string tag, input int e_cnt, input int e_top,
                               input logic e_ovf, input logic e_unf);
        check({tag, ".count"}, 32'(count), 32'(e_cnt));
        check({tag, ".top"},   32'(top_addr), 32'(e_top));
        check({tag, ".empty"}, 32'(empty), 32'(e_cnt == 0));
        check({tag, ".full"},  32'(full), 32'(e_cnt == DEPTH));
        check({tag, ".ovf"},   32'(overflow_err), 32'(e_ovf));
        check({tag, ".unf"},   32'(underflow_err), 32'(e_unf));
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        push_addr = '0;
        stack_clr = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_state("reset", 0, 0, 1'b0, 1'b0);

        // Basic push/pop.
        step(1, 0, 12'h010, 0, 0);
        step(1, 0, 12'h020, 0, 0);
        step(1, 0, 12'h030, 0, 0);
        check_state("push3", 3, 'h030, 1'b0, 1'b0);
        step(0, 1, 12'h000, 0, 0);
        check_state("pop1", 2, 'h020, 1'b0, 1'b0);
        step(0, 0, 12'h000, 0, 0);
        check_state("idle", 2, 'h020, 1'b0, 1'b0);
        step(0, 1, 12'h000, 0, 0);
        step(0, 1, 12'h000, 0, 0);
        check_state("drain", 0, 0, 1'b0, 1'b0);

        // Fill to full, then overflow once.
        for (int i = 1; i <= 8; i++) step(1, 0, 12'(i), 0, 0);
        check_state("fill8", 8, 'h008, 1'b0, 1'b0);
        step(1, 0, 12'h009, 0, 0);
        check_state("ovf", 8, 'h009, 1'b1, 1'b0);
        for (int i = 9; i >= 2; i--) begin
            check("lifo.top", 32'(top_addr), 32'(i));
            step(0, 1, 12'h000, 0, 0);
        end
        check_state("ovf_drain", 0, 0, 1'b1, 1'b0);
        step(0, 0, 12'h000, 0, 1);
        check_state("ovf_clr", 0, 0, 1'b0, 1'b0);

        // Underflow, clearing it, and a new event winning over err_clr.
        step(0, 1, 12'h000, 0, 0);
        check_state("unf", 0, 0, 1'b0, 1'b1);
        step(0, 0, 12'h000, 0, 1);
        check_state("unf_clr", 0, 0, 1'b0, 1'b0);
        step(0, 1, 12'h000, 0, 1);
        check_state("unf_win", 0, 0, 1'b0, 1'b1);
        step(0, 0, 12'h000, 0, 1);

        // Push and pop together on an empty stack: underflow, then push.
        step(1, 1, 12'h0BE, 0, 0);
        check_state("pp_empty", 1, 'h0BE, 1'b0, 1'b1);
        step(0, 1, 12'h000, 0, 1);
        check_state("pp_empty_pop", 0, 0, 1'b0, 0);

        // Push and pop together replace the top entry.
        step(1, 0, 12'h010, 0, 0);
        step(1, 0, 12'h020, 0, 0);
        step(1, 1, 12'h055, 0, 0);
        check_state("replace", 2, 'h055, 1'b0, 1'b0);
        step(0, 1, 12'h000, 0, 0);
        check_state("replace_pop", 1, 'h010, 1'b0, 1'b0);

        // stack_clr wins over push, with underflow_err set beforehand.
        step(0, 0, 12'h000, 1, 0);
        step(0, 1, 12'h000, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 12'(12'h100 + i), 0, 0);
        check_state("pre_clr", 5, 'h104, 1'b0, 1'b1);
        step(1, 0, 12'h777, 1, 0);
        check_state("clr", 0, 0, 1'b0, 1'b1);
        step(1, 0, 12'h0AA, 0, 0);
        check_state("post_clr", 1, 'h0AA, 1'b0, 1'b1);

        // rst asserted mid-sequence, with push and pop active at count 4 and overflow_err set.
        step(0, 0, 12'h000, 1, 1);
        for (int i = 0; i < 9; i++) step(1, 0, 12'(12'h200 + i), 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 12'h000, 0, 0);
        check_state("pre_rst", 4, 'h204, 1'b1, 1'b0);
        rst = 1'b1;
        step(1, 1, 12'h3FF, 1, 1);
        rst = 1'b0;
        check_state("rst_mid", 0, 0, 1'b0, 1'b0);
        step(1, 0, 12'h123, 0, 0);
        check_state("fresh", 1, 'h123, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
